// File: rtl/tetris_pixel_renderer.sv
// Tetris board pixel renderer: maps VGA coordinates to board cells, fetches cell codes
// from a 1-cycle board RAM and emits registered RGB with aligned syncs. Optional: GRID_LINES_EN.
module tetris_pixel_renderer #(
   parameter int         BOARD_X0     = 176,
   parameter int         BOARD_Y0     = 80,
   parameter int         CELL_SHIFT   = 4,
   parameter int         BOARD_COLS   = 10,
   parameter int         BOARD_ROWS   = 20,
   parameter int         BORDER_W     = 4,
   parameter logic [7:0] BORDER_COLOR = 8'b101_101_10,
   parameter logic [7:0] BG_COLOR     = 8'b000_000_01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] next_x,
   input  logic [9:0] next_y,
   input  logic       is_active,
   input  logic       h_sync_in,
   input  logic       v_sync_in,
   output logic [7:0] cell_addr,
   input  logic [2:0] cell_data,
   output logic [7:0] rgb,
   output logic       h_sync_out,
   output logic       v_sync_out,
   output logic       vblank_pulse
);

   localparam int BOARD_W = BOARD_COLS << CELL_SHIFT;
   localparam int BOARD_H = BOARD_ROWS << CELL_SHIFT;

   // Compares are done 11 bits wide so the frame bounds never wrap.
   localparam logic [10:0] X_LO  = 11'(BOARD_X0);
   localparam logic [10:0] X_HI  = 11'(BOARD_X0 + BOARD_W);
   localparam logic [10:0] Y_LO  = 11'(BOARD_Y0);
   localparam logic [10:0] Y_HI  = 11'(BOARD_Y0 + BOARD_H);
   localparam logic [10:0] FX_LO = 11'(BOARD_X0 - BORDER_W);
   localparam logic [10:0] FX_HI = 11'(BOARD_X0 + BOARD_W + BORDER_W);
   localparam logic [10:0] FY_LO = 11'(BOARD_Y0 - BORDER_W);
   localparam logic [10:0] FY_HI = 11'(BOARD_Y0 + BOARD_H + BORDER_W);

   logic [10:0] x_ext, y_ext;
   logic [9:0]  dx, dy;
   logic        in_board_c, in_frame_c, in_border_c;
   logic [3:0]  col_c;
   logic [4:0]  row_c;

   assign x_ext       = {1'b0, next_x};
   assign y_ext       = {1'b0, next_y};
   assign dx          = next_x - 10'(BOARD_X0);
   assign dy          = next_y - 10'(BOARD_Y0);
   assign in_board_c  = (x_ext >= X_LO) && (x_ext < X_HI) && (y_ext >= Y_LO) && (y_ext < Y_HI);
   assign in_frame_c  = (x_ext >= FX_LO) && (x_ext < FX_HI) && (y_ext >= FY_LO) && (y_ext < FY_HI);
   assign in_border_c = in_frame_c && !in_board_c;
   assign col_c       = 4'(dx >> CELL_SHIFT);
   assign row_c       = 5'(dy >> CELL_SHIFT);

   logic       act_s1, board_s1, border_s1, hs_s1, vs_s1;
   logic [3:0] col_s1;
   logic [4:0] row_s1;
   logic       act_s2, board_s2, border_s2, hs_s2, vs_s2;
   logic       act_s3, board_s3, border_s3, hs_s3, vs_s3;
   logic       vs_prev;
   logic [7:0] pix_c;

`ifdef GRID_LINES_EN
   logic grid_c, grid_s1, grid_s2, grid_s3;
   assign grid_c = (dx[CELL_SHIFT-1:0] == '0) || (dy[CELL_SHIFT-1:0] == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         grid_s1 <= 1'b0;
         grid_s2 <= 1'b0;
         grid_s3 <= 1'b0;
      end else begin
         grid_s1 <= grid_c;
         grid_s2 <= grid_s1;
         grid_s3 <= grid_s2;
      end
   end
`endif

   function automatic logic [7:0] palette(input logic [2:0] code);
      logic [7:0] c;
      case (code)
         3'd1:    c = 8'h1F;
         3'd2:    c = 8'h03;
         3'd3:    c = 8'hF4;
         3'd4:    c = 8'hFC;
         3'd5:    c = 8'h1C;
         3'd6:    c = 8'hE3;
         3'd7:    c = 8'hE0;
         default: c = 8'h00;
      endcase
      return c;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         act_s1    <= 1'b0;
         board_s1  <= 1'b0;
         border_s1 <= 1'b0;
         hs_s1     <= 1'b1;
         vs_s1     <= 1'b1;
         col_s1    <= '0;
         row_s1    <= '0;
         act_s2    <= 1'b0;
         board_s2  <= 1'b0;
         border_s2 <= 1'b0;
         hs_s2     <= 1'b1;
         vs_s2     <= 1'b1;
         cell_addr <= '0;
         act_s3    <= 1'b0;
         board_s3  <= 1'b0;
         border_s3 <= 1'b0;
         hs_s3     <= 1'b1;
         vs_s3     <= 1'b1;
         rgb       <= '0;
         h_sync_out   <= 1'b1;
         v_sync_out   <= 1'b1;
         vs_prev      <= 1'b1;
         vblank_pulse <= 1'b0;
      end else begin
         act_s1    <= is_active;
         board_s1  <= in_board_c;
         border_s1 <= in_border_c;
         hs_s1     <= h_sync_in;
         vs_s1     <= v_sync_in;
         col_s1    <= col_c;
         row_s1    <= row_c;

         act_s2    <= act_s1;
         board_s2  <= board_s1;
         border_s2 <= border_s1;
         hs_s2     <= hs_s1;
         vs_s2     <= vs_s1;
         // Off-board pixels leave the RAM address parked on the last board cell.
         if (board_s1)
            cell_addr <= 8'(row_s1 * BOARD_COLS) + 8'(col_s1);

         act_s3    <= act_s2;
         board_s3  <= board_s2;
         border_s3 <= border_s2;
         hs_s3     <= hs_s2;
         vs_s3     <= vs_s2;

         rgb        <= pix_c;
         h_sync_out <= hs_s3;
         v_sync_out <= vs_s3;

         vs_prev      <= v_sync_in;
         vblank_pulse <= vs_prev && !v_sync_in;
      end
   end

   always_comb begin
      pix_c = BG_COLOR;
      if (!act_s3)
         pix_c = 8'h00;
      else if (board_s3) begin
         pix_c = palette(cell_data);
`ifdef GRID_LINES_EN
         if (cell_data == 3'd0 && grid_s3)
            pix_c = 8'b010_010_01;
`endif
      end else if (border_s3)
         pix_c = BORDER_COLOR;
   end

endmodule
